// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcodes, HALT word and fetch FSM state encoding
package instr_fetch_unit_pkg;

  typedef enum logic [3:0] {
    OP_VADD = 4'h0,
    OP_VDOT = 4'h1,
    OP_SMUL = 4'h2,
    OP_SST  = 4'h3,
    OP_VLD  = 4'h4,
    OP_VST  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SLH  = 4'h7,
    OP_J    = 4'h8,
    OP_NOP  = 4'hF
  } opcode_e;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_e;

  function automatic logic is_jump(input logic [15:0] word);
    return word[15:12] == OP_J;
  endfunction

  function automatic logic is_halt(input logic [15:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - PC register with sequential / J-target next-PC selection
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic [15:0]   instr,
  input  logic [AW-1:0] instr_pc,
  output logic [AW-1:0] pc
);

  localparam int XW = AW + 12;

  logic [XW-1:0] offset_x;
  logic [XW-1:0] target_x;
  logic [AW-1:0] next_pc;
  logic          unused_target_hi;

  // Add in a width wide enough for any sign-extended offset, then wrap to AW bits.
  assign offset_x         = XW'($signed(instr[11:0]));
  assign target_x         = XW'(instr_pc) + offset_x;
  assign unused_target_hi = ^target_x[XW-1:AW];
  assign next_pc          = is_jump(instr) ? target_x[AW-1:0] : instr_pc + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch FSM; FETCH_HALT_EN enables HALT
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [15:0]   imem_rdata,
  output logic          instr_valid,
  output logic [15:0]   instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  output logic          halted
);

  fetch_state_e  state, state_nxt;
  logic [AW-1:0] pc;
  logic          advance;
  logic          halting;

  assign advance = (state == ST_HOLD) && instr_ready;

`ifdef FETCH_HALT_EN
  assign halting = is_halt(instr);
  assign halted  = (state == ST_HALT);
`else
  assign halting = 1'b0;
  assign halted  = 1'b0;
`endif

  fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .instr    (instr),
    .instr_pc (instr_pc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: if (imem_rvalid) state_nxt = ST_HOLD;
      ST_HOLD: if (instr_ready) state_nxt = halting ? ST_HALT : ST_REQ;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Responses are only taken in WAIT, so stale or stray rvalid pulses never reach the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= 16'h0000;
      instr_pc <= '0;
    end else if ((state == ST_WAIT) && imem_rvalid) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b1;
  logic        halted;

  instr_fetch_unit #(.AW(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int cnt = 0;
  logic [7:0] paddr = 8'h0;
  int stall_pc = -1;
  int stall_left = 0;
  bit spur_arm = 1'b0;
  bit stale_arm = 1'b0;
  bit req_seen = 1'b0;
  int m_pc = 0;
  bit m_halted = 1'b0;
  bit m_out = 1'b0;
  int cyc = 0;
  int addr_q[$];
  int reqc_q[$];
  logic [15:0] acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural next PC: J adds the signed 12-bit offset, everything else steps by one.
  function automatic int model_next(input int pc, input logic [15:0] w);
    int off;
    if (w[15:12] == 4'h8) begin
      off = int'(w[11:0]);
      if (off >= 2048) off = off - 4096;
      return ((pc + off) % 256 + 256) % 256;
    end
    return (pc + 1) % 256;
  endfunction

  // Per-cycle: compare against the model, then play memory and decoder for the next edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {5'b0, imem_req, instr_valid, halted, instr, instr_pc}, 32'h0);
      m_pc = 0;
      m_halted = 1'b0;
      m_out = 1'b0;
      cnt = 0;
      imem_rvalid = 1'b0;
      instr_ready = 1'b1;
    end else begin
      if (imem_req) begin
        chk("req_addr", {24'h0, imem_addr}, m_pc);
        chk("req_single_outstanding", {31'h0, m_out | instr_valid}, 32'h0);
        m_out = 1'b1;
        addr_q.push_back(int'(imem_addr));
        reqc_q.push_back(cyc);
        req_seen = 1'b1;
      end
      if (instr_valid) begin
        chk("instr", {16'h0, instr}, {16'h0, mem[m_pc]});
        chk("instr_pc", {24'h0, instr_pc}, m_pc);
      end
      chk("halted", {31'h0, halted}, {31'h0, m_halted});
      if (m_halted) chk("halt_quiet", {30'h0, imem_req, instr_valid}, 32'h0);

      imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem[paddr];
        end
      end
      if (spur_arm && instr_valid) begin
        imem_rvalid = 1'b1;
        imem_rdata = 16'hBAD0;
        spur_arm = 1'b0;
      end
      if (stale_arm) begin
        imem_rvalid = 1'b1;
        imem_rdata = 16'hDEAD;
        stale_arm = 1'b0;
      end
      if (imem_req) begin
        cnt = lat;
        paddr = imem_addr;
      end

      if (instr_valid && stall_left > 0 && int'(instr_pc) == stall_pc) begin
        instr_ready = 1'b0;
        stall_left--;
      end else begin
        instr_ready = 1'b1;
      end

      if (instr_valid && instr_ready) begin
        acc_q.push_back(instr);
        if (HALT_EN && mem[m_pc] == 16'hFFFF) m_halted = 1'b1;
        m_pc = model_next(m_pc, mem[m_pc]);
        m_out = 1'b0;
      end
    end
  end

  task automatic start_phase();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    addr_q.delete();
    reqc_q.delete();
    acc_q.delete();
    stall_pc = -1;
    stall_left = 0;
  endtask

  initial begin
    int exp_a[9];
    exp_a = '{0, 1, 2, 3, 4, 16, 14, 255, 0};
    for (int i = 0; i < 256; i++) mem[i] = 16'h7000;

    // Sequential words, then a J chain 4->0x10->0x0E->0xFF->0x00 (wrap).
    mem[0] = 16'h0000; mem[1] = 16'h1000; mem[2] = 16'h2000; mem[3] = 16'h3000;
    mem[4] = 16'h800C; mem[8'h10] = 16'h8FFE; mem[8'h0E] = 16'h80F1; mem[8'hFF] = 16'h8001;
    lat = 1;
    stall_pc = 1;
    stall_left = 5;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    chk("p1_req_count", {31'h0, addr_q.size() >= 9}, 32'h1);
    for (int i = 0; i < 9; i++) chk("p1_addr_seq", addr_q[i], exp_a[i]);
    chk("p1_gap_0_1", reqc_q[1] - reqc_q[0], 3);
    chk("p1_gap_stall", reqc_q[2] - reqc_q[1], 8);
    chk("p1_gap_2_3", reqc_q[3] - reqc_q[2], 3);
    chk("p1_acc_pc1", {16'h0, acc_q[1]}, 32'h1000);

    // Four-cycle memory plus a stray rvalid while the first word is stalled in HOLD.
    start_phase();
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    lat = 4;
    stall_pc = 0;
    stall_left = 3;
    spur_arm = 1'b1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    chk("p2_acc0", {16'h0, acc_q[0]}, 32'h1234);
    chk("p2_acc1", {16'h0, acc_q[1]}, 32'h5678);
    chk("p2_gap", reqc_q[1] - reqc_q[0], 9);

    // Reset while waiting on memory; a stale response lands just after release.
    start_phase();
    mem[0] = 16'hA5A5;
    lat = 2;
    req_seen = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (req_seen) break;
    end
    chk("p3_req_seen", {31'h0, req_seen}, 32'h1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    addr_q.delete();
    reqc_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #2;
    stale_arm = 1'b1;
    repeat (20) @(posedge clk);
    chk("p3_first_addr", addr_q[0], 0);
    chk("p3_first_instr", {16'h0, acc_q[0]}, 32'hA5A5);

    // 16'hFFFF at pc 3: HALT when enabled, plain NOP otherwise.
    start_phase();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hFFFF; mem[4] = 16'h4444;
    lat = 1;
    rst_n = 1'b1;
    repeat (36) @(posedge clk);
    #2;
`ifdef FETCH_HALT_EN
    chk("p4_halted", {31'h0, halted}, 32'h1);
    chk("p4_req_count", addr_q.size(), 4);
    chk("p4_acc_count", acc_q.size(), 4);
`else
    chk("p4_not_halted", {31'h0, halted}, 32'h0);
    chk("p4_addr_after_nop", addr_q[4], 4);
    chk("p4_acc_after_nop", {16'h0, acc_q[4]}, 32'h4444);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
